conv_encoder_param: RTL and testbench

Parametrised rate-1/2 feed-forward convolutional encoder. It is the next generation of the fixed K=9 encoder, adding configurable constraint length and generator polynomials, valid/ready handshakes on both sides, and frame termination with automatic zero-tail flushing. It sits between the frame source and the modulator/interleaver and feeds the Viterbi decoder test path.

---
 rtl/conv_encoder_param.sv | 137 +++++++++++++
 tb/tb_conv_encoder_param.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/conv_encoder_param.sv
// Parametrised rate-1/2 feed-forward convolutional encoder with zero-tail flush.
// Define PUNCTURE_EN for rate-2/3 puncturing (pattern 11,10 per frame).
module conv_encoder_param #(
   parameter int             K      = 9,
   parameter logic [K-1:0]   POLY_A = 9'b110_101_111,
   parameter logic [K-1:0]   POLY_B = 9'b100_011_101
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       in_data,
   input  logic       in_last,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [1:0] out_data,
   output logic [1:0] out_mask,
   output logic       out_last,
   output logic       busy
);

   localparam int CW = $clog2(K);

   typedef enum logic {RUN, TAIL} stateT;

   stateT          state, stateNxt;
   logic [K-2:0]   sr, srNxt;
   logic [CW-1:0]  tailCnt, tailNxt;
   logic           outValid, validNxt;
   logic [1:0]     outData, dataNxt;
   logic           outLast, lastNxt;
   logic           advance, fire, lastSym, feedBit;
   logic [K-1:0]   word;

`ifdef PUNCTURE_EN
   logic           phase, phaseNxt;
   logic [1:0]     outMask, maskNxt;
`endif

   assign advance   = !outValid || out_ready;
   // Gated by reset so nothing is offered upstream while held in reset.
   assign in_ready  = Reset && (state == RUN) && advance;
   assign busy      = (state == TAIL);
   assign out_valid = outValid;
   assign out_data  = outData;
   assign out_last  = outLast;

`ifdef PUNCTURE_EN
   assign out_mask = outMask;
`else
   assign out_mask = 2'b11;
`endif

   always_comb begin
      stateNxt = state;
      srNxt    = sr;
      tailNxt  = tailCnt;
      validNxt = outValid;
      dataNxt  = outData;
      lastNxt  = outLast;
      fire     = 1'b0;
      lastSym  = 1'b0;
`ifdef PUNCTURE_EN
      phaseNxt = phase;
      maskNxt  = outMask;
`endif
      feedBit  = (state == RUN) ? in_data : 1'b0;
      word     = {feedBit, sr};

      unique case (state)
         RUN: begin
            if (in_valid && in_ready) begin
               fire = 1'b1;
               if (in_last) begin
                  stateNxt = TAIL;
                  tailNxt  = '0;
               end
            end
         end
         TAIL: begin
            if (advance) begin
               fire    = 1'b1;
               tailNxt = tailCnt + CW'(1);
               if (tailCnt == CW'(K - 2)) begin
                  lastSym  = 1'b1;
                  stateNxt = RUN;
               end
            end
         end
      endcase

      if (fire) begin
         validNxt = 1'b1;
         dataNxt  = {^(POLY_A & word), ^(POLY_B & word)};
         lastNxt  = lastSym;
         srNxt    = word[K-1:1];
`ifdef PUNCTURE_EN
         if (phase) begin
            maskNxt    = 2'b10;
            dataNxt[0] = 1'b0;
         end else begin
            maskNxt = 2'b11;
         end
         phaseNxt = lastSym ? 1'b0 : !phase;
`endif
      end else if (out_ready) begin
         validNxt = 1'b0;
      end
   end

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         state    <= RUN;
         sr       <= '0;
         tailCnt  <= '0;
         outValid <= 1'b0;
         outData  <= 2'b00;
         outLast  <= 1'b0;
`ifdef PUNCTURE_EN
         phase    <= 1'b0;
         outMask  <= 2'b11;
`endif
      end else begin
         state    <= stateNxt;
         sr       <= srNxt;
         tailCnt  <= tailNxt;
         outValid <= validNxt;
         outData  <= dataNxt;
         outLast  <= lastNxt;
`ifdef PUNCTURE_EN
         phase    <= phaseNxt;
         outMask  <= maskNxt;
`endif
      end
   end

endmodule

// File: tb/tb_conv_encoder_param.sv
// Directed bench for conv_encoder_param (K=9, default polynomials).
// Covers impulse, zero frame, backpressure, back-to-back and mid-tail reset.
module tb_conv_encoder_param;

   logic       Clock = 1'b0;
   logic       Reset = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_data = 1'b0;
   logic       in_last = 1'b0;
   logic       out_ready = 1'b0;
   logic       in_ready, out_valid, out_last, busy;
   logic [1:0] out_data, out_mask;

   int errCnt = 0;
   int chkCnt = 0;
   int busyCyc;

   // {data, mask, last} per consumed symbol
   logic [4:0] symQ[$];

   logic [1:0] impTab [9] = '{2'b11, 2'b10, 2'b00, 2'b10, 2'b01,
                              2'b11, 2'b11, 2'b10, 2'b11};

   always #5 Clock = ~Clock;

   conv_encoder_param dut (
      .Clock    (Clock),
      .Reset    (Reset),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .in_last  (in_last),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .out_mask (out_mask),
      .out_last (out_last),
      .busy     (busy)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      chkCnt++;
      if (got !== exp) begin
         errCnt++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [1:0] expMask(input int j);
`ifdef PUNCTURE_EN
      return (j % 2) ? 2'b10 : 2'b11;
`else
      return 2'b11;
`endif
   endfunction

   function automatic logic [1:0] expImp(input int j);
      logic [1:0] v;
      v = impTab[j];
`ifdef PUNCTURE_EN
      if (j % 2) v[0] = 1'b0;
`endif
      return v;
   endfunction

   task automatic doReset();
      @(negedge Clock);
      Reset    = 1'b0;
      in_valid = 1'b0;
      in_last  = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(negedge Clock);
      check("rstValid", out_valid, 0);
      check("rstData", out_data, 2'b00);
      check("rstMask", out_mask, 2'b11);
      check("rstLast", out_last, 0);
      check("rstBusy", busy, 0);
      check("rstReady", in_ready, 0);
      Reset = 1'b1;
      #1;
      check("readyAfterRst", in_ready, 1);
   endtask

   task automatic runFrames(input int nBits, input logic [31:0] bits,
                            input logic [31:0] lasts, input int nSym,
                            input bit stall);
      int idx = 0;
      int cyc = 0;
      bit held = 1'b0;
      logic [4:0] heldVal = '0;
      symQ.delete();
      busyCyc = 0;
      while (symQ.size() < nSym && cyc < 400) begin
         @(negedge Clock);
         out_ready = stall ? (cyc % 3 == 0) : 1'b1;
         in_valid  = (idx < nBits);
         in_data   = bits[idx];
         in_last   = lasts[idx];
         #1;
         if (held)
            check("holdStable", {out_valid, out_data, out_mask, out_last},
                  {1'b1, heldVal});
         held    = out_valid && !out_ready;
         heldVal = {out_data, out_mask, out_last};
         if (held) check("noAcceptStall", in_ready, 0);
         if (busy) begin
            busyCyc++;
            check("readyInTail", in_ready, 0);
         end
         if (out_valid && out_ready)
            symQ.push_back({out_data, out_mask, out_last});
         if (in_valid && in_ready) idx++;
         cyc++;
      end
      @(negedge Clock);
      in_valid = 1'b0;
      in_last  = 1'b0;
      check("symCount", symQ.size(), nSym);
   endtask

   task automatic checkImpulse(input string pfx, input int base);
      for (int j = 0; j < 9; j++) begin
         if (base + j < symQ.size()) begin
            check($sformatf("%s_d%0d", pfx, j), symQ[base+j][4:3], expImp(j));
            check($sformatf("%s_m%0d", pfx, j), symQ[base+j][2:1], expMask(j));
            check($sformatf("%s_l%0d", pfx, j), symQ[base+j][0], (j == 8));
         end else begin
            check($sformatf("%s_miss%0d", pfx, j), 0, 1);
         end
      end
   endtask

   initial begin
      doReset();

      runFrames(1, 32'h1, 32'h1, 9, 1'b0);
      checkImpulse("imp", 0);
      check("impBusyCyc", busyCyc, 8);

      runFrames(16, 32'h0, 32'h8000, 24, 1'b0);
      for (int j = 0; j < symQ.size(); j++) begin
         check($sformatf("zero_d%0d", j), symQ[j][4:3], 2'b00);
         check($sformatf("zero_m%0d", j), symQ[j][2:1], expMask(j));
         check($sformatf("zero_l%0d", j), symQ[j][0], (j == 23));
      end
      check("zeroBusyCyc", busyCyc, 8);

      runFrames(1, 32'h1, 32'h1, 9, 1'b1);
      checkImpulse("bp", 0);

      runFrames(2, 32'h3, 32'h3, 18, 1'b0);
      checkImpulse("b2bA", 0);
      checkImpulse("b2bB", 9);

      // Impulse frame interrupted by reset while tail symbol j=4 is shown
      @(negedge Clock);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 1'b1;
      in_last   = 1'b1;
      @(negedge Clock);
      in_valid = 1'b0;
      in_last  = 1'b0;
      repeat (4) @(negedge Clock);
      check("midTailSym", out_data, expImp(4));
      check("midTailBusy", busy, 1);
      Reset = 1'b0;
      @(posedge Clock);
      #1;
      check("rstDropValid", out_valid, 0);
      check("rstDropBusy", busy, 0);
      @(negedge Clock);
      Reset = 1'b1;
      runFrames(1, 32'h1, 32'h1, 9, 1'b0);
      checkImpulse("afterRst", 0);

      $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
      $finish;
   end

endmodule
